sea_battle_game_sequencer: RTL and testbench
============================================

// Module: sea_battle_game_sequencer
//
// PURPOSE
//   Game-flow controller for the sea battle VGA game. Sits between the player buttons, the
//   frame timing from the VGA sync generator and the sprite/collision datapath. Sequences
//   attract -> play -> explosion -> game-over phases, issues ship-respawn and torpedo-launch
//   commands, and keeps score and remaining shots.
//
// PARAMETERS
//   SHOTS_PER_GAME   8    torpedoes per game, >=1
//   SCORE_W          4    score counter width; score saturates at 2**SCORE_W-1
//   EXPLODE_FRAMES   32   frames spent in EXPLODE, >=1
//   OVER_FRAMES      120  frames spent in GAME_OVER before ATTRACT, >=1
//
// PORTS
//   clk              in   1        system clock (pixel clock domain)
//   rst              in   1        synchronous reset, active high
//   frame_tick       in   1        1-cycle pulse once per frame (start of vertical blank)
//   left             in   1        raw button, already synchronised to clk; START / restart
//   right            in   1        raw button, already synchronised to clk; FIRE
//   torpedo_hit      in   1        1-cycle pulse from collision detect: torpedo hit the ship
//   torpedo_gone     in   1        1-cycle pulse: torpedo left the screen
//   ship_escaped     in   1        1-cycle pulse: ship left the screen
//   ship_respawn     out  1        1-cycle pulse: datapath reloads ship at start position
//   torpedo_launch   out  1        1-cycle pulse: datapath launches torpedo from the gun
//   ship_active      out  1        ship sprite enabled
//   torpedo_active   out  1        torpedo sprite enabled
//   explosion_active out  1        explosion sprite enabled
//   palette_sel      out  2        0 normal, 1 flash, 2 game over, 3 attract
//   score            out  SCORE_W  hits this game
//   shots_left       out  $clog2(SHOTS_PER_GAME+1)  torpedoes remaining
//
// BEHAVIOUR
//   - All outputs registered. Reset: state ATTRACT, every output 0 except palette_sel=3;
//     score=0, shots_left=0, timers and press detectors cleared. Reset mid-game aborts at once.
//   - Press detection: each button sampled only on frame_tick. press = sample high on two
//     consecutive frame_ticks after at least one low sample. One pulse per press, no repeat.
//     Pulse is internal and lasts one cycle, on the cycle after the qualifying frame_tick.
//   - Response latency: outputs change on the cycle after the triggering input or press.
//   - States and transitions:
//     ATTRACT : palette 3, all sprites off. left press -> READY; load score=0, shots_left=SHOTS_PER_GAME.
//     READY   : one cycle. ship_respawn=1 -> AIM.
//     AIM     : ship_active=1. right press with shots_left>0 -> torpedo_launch=1, shots_left-1,
//               -> FLIGHT. ship_escaped -> READY. shots_left==0 -> GAME_OVER.
//     FLIGHT  : ship_active=1, torpedo_active=1. torpedo_hit -> score+1 (saturating), -> EXPLODE.
//               torpedo_gone -> AIM. ship_escaped -> ship_respawn pulse, stay in FLIGHT.
//               right press is ignored: one torpedo in flight at a time.
//     EXPLODE : explosion_active=1, palette 1 on odd frame count, 0 on even. After
//               EXPLODE_FRAMES frame_ticks -> READY, or GAME_OVER if shots_left==0.
//     GAME_OVER: palette 2, sprites off, score and shots_left held. After OVER_FRAMES
//               frame_ticks -> ATTRACT. Presses ignored.
//   - Simultaneous events in FLIGHT: torpedo_hit beats torpedo_gone. ship_escaped with
//     torpedo_hit: the hit wins and no respawn pulse is issued. ship_escaped with
//     torpedo_gone: respawn pulse is issued and the next state is AIM.
//   - Frame timer counts frame_tick only. Width is $clog2(max(EXPLODE_FRAMES,OVER_FRAMES)+1).
//     The timer clears on every state entry.
//   - Inputs that do not apply to the current state are ignored (e.g. torpedo_hit in AIM).
//
// STRUCTURE
//   - sea_battle_pkg holds: the state enum typedef (ATTRACT, READY, AIM, FLIGHT, EXPLODE,
//     GAME_OVER) and the palette_sel code localparams (PAL_NORMAL, PAL_FLASH, PAL_OVER,
//     PAL_ATTRACT).
//   - Sub-module button_press_detector (clk, rst, frame_tick, btn -> press): frame-sampled
//     debounce plus edge detect. Instantiated twice, once per button.
//   - Top level holds a single next-state always_comb block, registered outputs, counters.
//
// TESTING
//   1. rst high 3 cycles mid-FLIGHT -> next cycle state ATTRACT, all outs 0, palette_sel=3.
//   2. left held 2 frame_ticks in ATTRACT -> READY, then ship_respawn for exactly 1 cycle,
//      shots_left=8, score=0.
//   3. AIM, right press -> torpedo_launch 1 cycle, shots_left 8->7. right held 10 frames
//      -> only 1 launch. 1-frame glitch on right -> no launch.
//   4. FLIGHT, torpedo_hit and torpedo_gone in the same cycle -> EXPLODE, score+1.
//      After 32 frame_ticks -> READY. palette alternates 1/0 per frame during EXPLODE.
//   5. SCORE_W=2, 5 hits -> score sticks at 3. Eighth shot ends with torpedo_gone ->
//      GAME_OVER, palette 2, presses ignored. After 120 frame_ticks -> ATTRACT.
//   6. FLIGHT, ship_escaped alone -> ship_respawn pulse, state stays FLIGHT, torpedo_active
//      stays 1.

Source files
------------

// File: rtl/sea_battle_pkg.sv
// Shared types and palette codes for the sea battle game-flow controller.
package sea_battle_pkg;

    typedef enum logic [2:0] {
        ATTRACT   = 3'd0,
        READY     = 3'd1,
        AIM       = 3'd2,
        FLIGHT    = 3'd3,
        EXPLODE   = 3'd4,
        GAME_OVER = 3'd5
    } state_e;

    localparam logic [1:0] PAL_NORMAL  = 2'd0;
    localparam logic [1:0] PAL_FLASH   = 2'd1;
    localparam logic [1:0] PAL_OVER    = 2'd2;
    localparam logic [1:0] PAL_ATTRACT = 2'd3;

endpackage

// File: rtl/button_press_detector.sv
// Frame-rate button debounce: one press pulse after two high frame samples that follow a low one.
module button_press_detector (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_frame_tick,
    input  logic i_btn,
    output logic o_press
);

    logic r_prev;
    logic r_armed;

    // r_armed blocks auto-repeat until the button has been seen released
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_prev  <= 1'b0;
            r_armed <= 1'b0;
            o_press <= 1'b0;
        end else begin
            o_press <= 1'b0;
            if (i_frame_tick) begin
                r_prev <= i_btn;
                if (!i_btn) begin
                    r_armed <= 1'b1;
                end else if (r_prev && r_armed) begin
                    o_press <= 1'b1;
                    r_armed <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/sea_battle_game_sequencer.sv
// Game-flow controller: attract -> play -> explosion -> game-over, with score and shot bookkeeping.
module sea_battle_game_sequencer
    import sea_battle_pkg::*;
#(
    parameter int unsigned SHOTS_PER_GAME = 8,
    parameter int unsigned SCORE_W        = 4,
    parameter int unsigned EXPLODE_FRAMES = 32,
    parameter int unsigned OVER_FRAMES    = 120
) (
    input  logic                                  i_clk,
    input  logic                                  i_rst,
    input  logic                                  i_frame_tick,
    input  logic                                  i_left,
    input  logic                                  i_right,
    input  logic                                  i_torpedo_hit,
    input  logic                                  i_torpedo_gone,
    input  logic                                  i_ship_escaped,
    output logic                                  o_ship_respawn,
    output logic                                  o_torpedo_launch,
    output logic                                  o_ship_active,
    output logic                                  o_torpedo_active,
    output logic                                  o_explosion_active,
    output logic [1:0]                            o_palette_sel,
    output logic [SCORE_W-1:0]                    o_score,
    output logic [$clog2(SHOTS_PER_GAME+1)-1:0]   o_shots_left
);

    localparam int unsigned SHOTS_W   = $clog2(SHOTS_PER_GAME + 1);
    localparam int unsigned TIMER_MAX = (EXPLODE_FRAMES > OVER_FRAMES) ? EXPLODE_FRAMES : OVER_FRAMES;
    localparam int unsigned TIMER_W   = $clog2(TIMER_MAX + 1);

    state_e               r_state;
    logic [TIMER_W-1:0]   r_timer;

    state_e               w_state_nxt;
    logic [TIMER_W-1:0]   w_timer_nxt;
    logic [SCORE_W-1:0]   w_score_nxt;
    logic [SHOTS_W-1:0]   w_shots_nxt;
    logic                 w_respawn_nxt;
    logic                 w_launch_nxt;
    logic                 w_flight_respawn;
    logic [1:0]           w_palette_nxt;
    logic                 w_press_left;
    logic                 w_press_right;

    button_press_detector u_left_press (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_frame_tick (i_frame_tick),
        .i_btn        (i_left),
        .o_press      (w_press_left)
    );

    button_press_detector u_right_press (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_frame_tick (i_frame_tick),
        .i_btn        (i_right),
        .o_press      (w_press_right)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state            <= ATTRACT;
            r_timer            <= '0;
            o_ship_respawn     <= 1'b0;
            o_torpedo_launch   <= 1'b0;
            o_ship_active      <= 1'b0;
            o_torpedo_active   <= 1'b0;
            o_explosion_active <= 1'b0;
            o_palette_sel      <= PAL_ATTRACT;
            o_score            <= '0;
            o_shots_left       <= '0;
        end else begin
            r_state            <= w_state_nxt;
            r_timer            <= w_timer_nxt;
            o_ship_respawn     <= w_respawn_nxt;
            o_torpedo_launch   <= w_launch_nxt;
            o_ship_active      <= (w_state_nxt == AIM) || (w_state_nxt == FLIGHT);
            o_torpedo_active   <= (w_state_nxt == FLIGHT);
            o_explosion_active <= (w_state_nxt == EXPLODE);
            o_palette_sel      <= w_palette_nxt;
            o_score            <= w_score_nxt;
            o_shots_left       <= w_shots_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_score_nxt      = o_score;
        w_shots_nxt      = o_shots_left;
        w_launch_nxt     = 1'b0;
        w_flight_respawn = 1'b0;
        w_timer_nxt      = r_timer;
        w_palette_nxt    = PAL_NORMAL;

        case (r_state)
            ATTRACT: begin
                if (w_press_left) begin
                    w_state_nxt = READY;
                    w_score_nxt = '0;
                    w_shots_nxt = SHOTS_W'(SHOTS_PER_GAME);
                end
            end
            READY: w_state_nxt = AIM;
            AIM: begin
                if (o_shots_left == '0) begin
                    w_state_nxt = GAME_OVER;
                end else if (i_ship_escaped) begin
                    w_state_nxt = READY;
                end else if (w_press_right) begin
                    w_state_nxt  = FLIGHT;
                    w_launch_nxt = 1'b1;
                    w_shots_nxt  = o_shots_left - SHOTS_W'(1);
                end
            end
            // a hit masks both torpedo_gone and ship_escaped in the same cycle
            FLIGHT: begin
                if (i_torpedo_hit) begin
                    w_state_nxt = EXPLODE;
                    w_score_nxt = (o_score == '1) ? o_score : o_score + SCORE_W'(1);
                end else begin
                    w_flight_respawn = i_ship_escaped;
                    if (i_torpedo_gone) begin
                        w_state_nxt = AIM;
                    end
                end
            end
            EXPLODE: begin
                if (i_frame_tick && (r_timer == TIMER_W'(EXPLODE_FRAMES - 1))) begin
                    w_state_nxt = (o_shots_left == '0) ? GAME_OVER : READY;
                end
            end
            GAME_OVER: begin
                if (i_frame_tick && (r_timer == TIMER_W'(OVER_FRAMES - 1))) begin
                    w_state_nxt = ATTRACT;
                end
            end
            default: w_state_nxt = ATTRACT;
        endcase

        if (w_state_nxt != r_state) begin
            w_timer_nxt = '0;
        end else if (i_frame_tick && ((r_state == EXPLODE) || (r_state == GAME_OVER))) begin
            w_timer_nxt = r_timer + TIMER_W'(1);
        end

        w_respawn_nxt = w_flight_respawn || (w_state_nxt == READY);

        case (w_state_nxt)
            ATTRACT:   w_palette_nxt = PAL_ATTRACT;
            GAME_OVER: w_palette_nxt = PAL_OVER;
            EXPLODE:   w_palette_nxt = w_timer_nxt[0] ? PAL_FLASH : PAL_NORMAL;
            default:   w_palette_nxt = PAL_NORMAL;
        endcase
    end

endmodule

// File: tb/tb_sea_battle_game_sequencer.sv
// Scenario bench for the sea battle game sequencer; respawn/launch pulses are scoreboarded.
module tb_sea_battle_game_sequencer;

    localparam int unsigned SCORE_W = 2;

    typedef struct packed {
        logic [7:0] kind;   // 0 respawn, 1 launch
        logic [7:0] shots;
        logic [7:0] score;
    } ev_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         tick = 1'b0;
    logic         left = 1'b0;
    logic         right = 1'b0;
    logic         hit = 1'b0;
    logic         gone = 1'b0;
    logic         esc = 1'b0;
    logic         o_respawn, o_launch, o_ship, o_torp, o_expl;
    logic [1:0]   o_pal;
    logic [SCORE_W-1:0] o_score;
    logic [3:0]   o_shots;

    ev_t exp_q[$];
    ev_t obs_mem[256];
    int  obs_wr = 0;
    int  obs_rd = 0;
    int  n_pass = 0;
    int  n_total = 0;

    sea_battle_game_sequencer #(
        .SHOTS_PER_GAME (8),
        .SCORE_W        (SCORE_W),
        .EXPLODE_FRAMES (32),
        .OVER_FRAMES    (120)
    ) dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .i_frame_tick       (tick),
        .i_left             (left),
        .i_right            (right),
        .i_torpedo_hit      (hit),
        .i_torpedo_gone     (gone),
        .i_ship_escaped     (esc),
        .o_ship_respawn     (o_respawn),
        .o_torpedo_launch   (o_launch),
        .o_ship_active      (o_ship),
        .o_torpedo_active   (o_torp),
        .o_explosion_active (o_expl),
        .o_palette_sel      (o_pal),
        .o_score            (o_score),
        .o_shots_left       (o_shots)
    );

    always #5 clk = ~clk;

    // Every cycle a pulse output is high becomes one observed event
    always @(negedge clk) begin
        if (o_respawn) begin
            obs_mem[obs_wr % 256] = '{8'd0, 8'(o_shots), 8'(o_score)};
            obs_wr++;
        end
        if (o_launch) begin
            obs_mem[obs_wr % 256] = '{8'd1, 8'(o_shots), 8'(o_score)};
            obs_wr++;
        end
    end

    function automatic ev_t ev(input int k, input int s, input int c);
        ev = '{8'(k), 8'(s), 8'(c)};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic frame();
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        cyc();
        cyc();
    endtask

    task automatic pulse(input logic h, input logic g, input logic e);
        hit = h; gone = g; esc = e;
        cyc();
        hit = 1'b0; gone = 1'b0; esc = 1'b0;
    endtask

    task automatic fire();
        right = 1'b1;
        frame();
        frame();
        right = 1'b0;
        frame();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) cyc();
        rst = 1'b0;
        n_total++;
        if ({o_respawn, o_launch, o_ship, o_torp, o_expl, o_pal, o_score, o_shots} !== {5'b0, 2'd3, 2'd0, 4'd0})
            $display("FAIL reset_outs: got %b want %b",
                     {o_respawn, o_launch, o_ship, o_torp, o_expl, o_pal, o_score, o_shots}, {5'b0, 2'd3, 2'd0, 4'd0});
        else n_pass++;
    endtask

    task automatic test_start();
        ev_t e, o;
        frame();
        frame();
        exp_q.push_back(ev(0, 8, 0));
        left = 1'b1;
        frame();
        frame();
        left = 1'b0;
        n_total++;
        if ({o_ship, o_torp, o_shots, o_score} !== {1'b1, 1'b0, 4'd8, 2'd0})
            $display("FAIL start_aim: got %b want %b", {o_ship, o_torp, o_shots, o_score}, {1'b1, 1'b0, 4'd8, 2'd0});
        else n_pass++;
        frame();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_rd != obs_wr) ? obs_mem[obs_rd % 256] : '1;
            if (obs_rd != obs_wr) obs_rd++;
            n_total++;
            if (o !== e) $display("FAIL start_pulse: got %h want %h", o, e); else n_pass++;
        end
        n_total++;
        if (obs_wr != obs_rd) $display("FAIL start_extra: got %0d extra pulses want 0", obs_wr - obs_rd); else n_pass++;
    endtask

    task automatic test_fire();
        ev_t e, o;
        right = 1'b1;
        frame();
        right = 1'b0;
        frame();
        n_total++;
        if ({obs_wr == obs_rd, o_torp, o_shots} !== {1'b1, 1'b0, 4'd8})
            $display("FAIL fire_glitch: got %b want %b", {obs_wr == obs_rd, o_torp, o_shots}, {1'b1, 1'b0, 4'd8});
        else n_pass++;
        exp_q.push_back(ev(1, 7, 0));
        right = 1'b1;
        for (int i = 0; i < 10; i++) begin
            frame();
            if (i == 3) pulse(1'b0, 1'b1, 1'b0);
        end
        right = 1'b0;
        frame();
        n_total++;
        if ({o_ship, o_torp, o_shots} !== {1'b1, 1'b0, 4'd7})
            $display("FAIL fire_held: got %b want %b", {o_ship, o_torp, o_shots}, {1'b1, 1'b0, 4'd7});
        else n_pass++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_rd != obs_wr) ? obs_mem[obs_rd % 256] : '1;
            if (obs_rd != obs_wr) obs_rd++;
            n_total++;
            if (o !== e) $display("FAIL fire_pulse: got %h want %h", o, e); else n_pass++;
        end
        n_total++;
        if (obs_wr != obs_rd) $display("FAIL fire_extra: got %0d extra pulses want 0", obs_wr - obs_rd); else n_pass++;
    endtask

    task automatic test_hit_explode();
        ev_t e, o;
        exp_q.push_back(ev(1, 6, 0));
        fire();
        n_total++;
        if (o_torp !== 1'b1) $display("FAIL explode_flight: got %b want 1", o_torp); else n_pass++;
        pulse(1'b1, 1'b1, 1'b0);
        n_total++;
        if ({o_expl, o_ship, o_torp, o_score, o_pal} !== {3'b100, 2'd1, 2'd0})
            $display("FAIL explode_entry: got %b want %b", {o_expl, o_ship, o_torp, o_score, o_pal}, {3'b100, 2'd1, 2'd0});
        else n_pass++;
        for (int k = 1; k <= 32; k++) begin
            if (k == 32) exp_q.push_back(ev(0, 6, 1));
            frame();
            if (k < 32) begin
                n_total++;
                if ({o_expl, o_pal} !== {1'b1, 2'(k % 2)})
                    $display("FAIL explode_pal%0d: got %b want %b", k, {o_expl, o_pal}, {1'b1, 2'(k % 2)});
                else n_pass++;
            end
        end
        n_total++;
        if ({o_ship, o_expl, o_pal} !== {2'b10, 2'd0})
            $display("FAIL explode_exit: got %b want %b", {o_ship, o_expl, o_pal}, {2'b10, 2'd0});
        else n_pass++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_rd != obs_wr) ? obs_mem[obs_rd % 256] : '1;
            if (obs_rd != obs_wr) obs_rd++;
            n_total++;
            if (o !== e) $display("FAIL explode_pulse: got %h want %h", o, e); else n_pass++;
        end
        n_total++;
        if (obs_wr != obs_rd) $display("FAIL explode_extra: got %0d extra pulses want 0", obs_wr - obs_rd); else n_pass++;
    endtask

    task automatic test_escape();
        ev_t e, o;
        exp_q.push_back(ev(1, 5, 1));
        fire();
        exp_q.push_back(ev(0, 5, 1));
        pulse(1'b0, 1'b0, 1'b1);
        cyc();
        n_total++;
        if ({o_ship, o_torp, o_expl} !== 3'b110)
            $display("FAIL escape_state: got %b want 110", {o_ship, o_torp, o_expl});
        else n_pass++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_rd != obs_wr) ? obs_mem[obs_rd % 256] : '1;
            if (obs_rd != obs_wr) obs_rd++;
            n_total++;
            if (o !== e) $display("FAIL escape_pulse: got %h want %h", o, e); else n_pass++;
        end
        n_total++;
        if (obs_wr != obs_rd) $display("FAIL escape_extra: got %0d extra pulses want 0", obs_wr - obs_rd); else n_pass++;
    endtask

    task automatic test_reset_mid_flight();
        rst = 1'b1;
        cyc();
        n_total++;
        if ({o_respawn, o_launch, o_ship, o_torp, o_expl, o_pal, o_score, o_shots} !== {5'b0, 2'd3, 2'd0, 4'd0})
            $display("FAIL midreset_first: got %b want %b",
                     {o_respawn, o_launch, o_ship, o_torp, o_expl, o_pal, o_score, o_shots}, {5'b0, 2'd3, 2'd0, 4'd0});
        else n_pass++;
        cyc();
        cyc();
        rst = 1'b0;
        cyc();
        n_total++;
        if ({o_respawn, o_launch, o_ship, o_torp, o_expl, o_pal, o_score, o_shots} !== {5'b0, 2'd3, 2'd0, 4'd0})
            $display("FAIL midreset_after: got %b want %b",
                     {o_respawn, o_launch, o_ship, o_torp, o_expl, o_pal, o_score, o_shots}, {5'b0, 2'd3, 2'd0, 4'd0});
        else n_pass++;
        n_total++;
        if (obs_wr != obs_rd) $display("FAIL midreset_extra: got %0d extra pulses want 0", obs_wr - obs_rd); else n_pass++;
    endtask

    task automatic test_game_over();
        ev_t e, o;
        int  sc;
        sc = 0;
        frame();
        exp_q.push_back(ev(0, 8, 0));
        left = 1'b1;
        frame();
        frame();
        left = 1'b0;
        frame();
        for (int s = 0; s < 8; s++) begin
            exp_q.push_back(ev(1, 7 - s, sc));
            fire();
            if (s < 5) begin
                sc = (sc < 3) ? sc + 1 : 3;
                pulse(1'b1, 1'b0, s == 0);
                n_total++;
                if ({o_expl, o_score} !== {1'b1, 2'(sc)})
                    $display("FAIL over_hit%0d: got %b want %b", s, {o_expl, o_score}, {1'b1, 2'(sc)});
                else n_pass++;
                for (int k = 1; k <= 32; k++) begin
                    if (k == 32) exp_q.push_back(ev(0, 7 - s, sc));
                    frame();
                end
            end else begin
                pulse(1'b0, 1'b1, 1'b0);
                cyc();
            end
        end
        n_total++;
        if ({o_pal, o_score, o_shots, o_ship, o_torp, o_expl} !== {2'd2, 2'd3, 4'd0, 3'b000})
            $display("FAIL over_entry: got %b want %b", {o_pal, o_score, o_shots, o_ship, o_torp, o_expl},
                     {2'd2, 2'd3, 4'd0, 3'b000});
        else n_pass++;
        left = 1'b1;
        frame();
        frame();
        left = 1'b0;
        frame();
        for (int f = 4; f <= 120; f++) begin
            frame();
            if (f == 119) begin
                n_total++;
                if (o_pal !== 2'd2) $display("FAIL over_hold: got %0d want 2", o_pal); else n_pass++;
            end
        end
        n_total++;
        if ({o_pal, o_score, o_shots, o_ship} !== {2'd3, 2'd3, 4'd0, 1'b0})
            $display("FAIL over_attract: got %b want %b", {o_pal, o_score, o_shots, o_ship}, {2'd3, 2'd3, 4'd0, 1'b0});
        else n_pass++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_rd != obs_wr) ? obs_mem[obs_rd % 256] : '1;
            if (obs_rd != obs_wr) obs_rd++;
            n_total++;
            if (o !== e) $display("FAIL over_pulse: got %h want %h", o, e); else n_pass++;
        end
        n_total++;
        if (obs_wr != obs_rd) $display("FAIL over_extra: got %0d extra pulses want 0", obs_wr - obs_rd); else n_pass++;
    endtask

    initial begin
        cyc();
        test_reset();
        test_start();
        test_fire();
        test_hit_explode();
        test_escape();
        test_reset_mid_flight();
        test_game_over();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
